// File: rtl/ram_imagen_pkg.sv
// Image geometry and derived sizes for the camera frame buffer.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ram_imagen_pkg;

  localparam int IMG_W       = 640;
  localparam int IMG_H       = 480;
  localparam int PIX_W       = 8;
  localparam int FRAME_BYTES = IMG_W * IMG_H;
  localparam int ADDR_W      = 19;

endpackage

// File: rtl/ram_imagen_if.sv
// Frame-buffer access bus: shared address, write data in, read data and full flag out.
// Latency: n/a (signal bundle only).
// Backpressure: none on the bus; the writer must gate its enable with !fin.
//   master : we_i, re_i, adr_i, dat_i out; dat_o, fin in
//   slave  : mirror of master
interface ram_imagen_if
  import ram_imagen_pkg::*;
#(
  parameter int DW = PIX_W,
  parameter int AW = ADDR_W
);

  logic          we_i;
  logic          re_i;
  logic [AW-1:0] adr_i;
  logic [DW-1:0] dat_i;
  logic [DW-1:0] dat_o;
  logic          fin;

  modport master (output we_i, re_i, adr_i, dat_i, input dat_o, fin);
  modport slave  (input we_i, re_i, adr_i, dat_i, output dat_o, fin);

endinterface

// File: rtl/ram_imagen_mem.sv
// Plain inferred single-address storage array, read-first, no reset on contents.
// Latency: 1 cycle read (registered o_dout, held while i_re=0).
// Backpressure: none; every enabled access completes on the clock edge.
//   clk_i, i_we, i_re, i_addr, i_din in; o_dout out
module ram_imagen_mem
  import ram_imagen_pkg::*;
#(
  parameter int DW    = PIX_W,
  parameter int AW    = ADDR_W,
  parameter int DEPTH = FRAME_BYTES
) (
  input  logic          clk_i,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_din,
  output logic [DW-1:0] o_dout
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_dout;

  // Read and write in the same block so a same-address access returns old data.
  always_ff @(posedge clk_i) begin
    if (i_we) begin
      r_mem[i_addr] <= i_din;
    end
    if (i_re) begin
      r_dout <= r_mem[i_addr];
    end
  end

  assign o_dout = r_dout;

endmodule

// File: rtl/ram_imagen.sv
// Camera frame buffer: range-checked byte writes until the last location, then frozen (fin).
// Latency: 1 cycle read; fin visible the cycle after the write to DEPTH-1.
// Backpressure: none; writes after fin or out of range are silently dropped.
//   clk_i, rst           : pixel clock, async active-high reset
//   bus (slave)          : we_i, re_i, adr_i, dat_i in; dat_o, fin out
module ram_imagen #(
  parameter int DATA_W = ram_imagen_pkg::PIX_W,
  parameter int ADDR_W = ram_imagen_pkg::ADDR_W,
  parameter int DEPTH  = ram_imagen_pkg::FRAME_BYTES
) (
  input  logic         clk_i,
  input  logic         rst,
  ram_imagen_if.slave  bus
);

  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] LAST_C  = DEPTH_C - 1'b1;

  logic              w_in_rng;
  logic              w_wr_en;
  logic              w_rd_en;
  logic [DATA_W-1:0] w_mem_dout;

  logic              r_fin;
  logic              r_rd_rng;

  assign w_in_rng = ({1'b0, bus.adr_i} < DEPTH_C);
  // A write on the same edge as reset is dropped; the array itself has no reset.
  assign w_wr_en  = bus.we_i & ~r_fin & w_in_rng & ~rst;
  assign w_rd_en  = bus.re_i & w_in_rng;

  ram_imagen_mem #(
    .DW    (DATA_W),
    .AW    (MEM_AW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i  (clk_i),
    .i_we   (w_wr_en),
    .i_re   (w_rd_en),
    .i_addr (bus.adr_i[MEM_AW-1:0]),
    .i_din  (bus.dat_i),
    .o_dout (w_mem_dout)
  );

  // r_rd_rng remembers whether the last read hit the array; it clears on reset so
  // dat_o drops to zero immediately without touching the RAM output register.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_fin    <= 1'b0;
      r_rd_rng <= 1'b0;
    end else begin
      if (w_wr_en && ({1'b0, bus.adr_i} == LAST_C)) begin
        r_fin <= 1'b1;
      end
      if (bus.re_i) begin
        r_rd_rng <= w_in_rng;
      end
    end
  end

  assign bus.fin   = r_fin;
  assign bus.dat_o = r_rd_rng ? w_mem_dout : '0;

endmodule

// File: tb/tb_ram_imagen.sv
// Self-checking bench for ram_imagen with a small DEPTH and a byte-array reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_ram_imagen;

  localparam int DW    = 8;
  localparam int AW    = 19;
  localparam int DEPTH = 16;

  logic clk_i = 1'b0;
  logic rst   = 1'b0;

  ram_imagen_if #(.DW(DW), .AW(AW)) bus ();

  ram_imagen #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk_i (clk_i),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference model
  logic [7:0] ref_mem   [DEPTH];
  bit         ref_known [DEPTH];
  logic [7:0] ref_dout;
  bit         ref_dk;
  logic       ref_fin;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    ref_fin  = 1'b0;
    ref_dout = 8'h00;
    ref_dk   = 1'b1;
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, check outputs.
  task automatic step(input bit we, input bit re, input int adr, input logic [7:0] d);
    logic [31:0] a;
    a = adr;
    bus.we_i  = we;
    bus.re_i  = re;
    bus.adr_i = a[AW-1:0];
    bus.dat_i = d;
    @(posedge clk_i);
    if (re) begin
      if (adr < DEPTH) begin
        ref_dout = ref_mem[adr];
        ref_dk   = ref_known[adr];
      end else begin
        ref_dout = 8'h00;
        ref_dk   = 1'b1;
      end
    end
    if (we && !ref_fin && adr < DEPTH) begin
      ref_mem[adr]   = d;
      ref_known[adr] = 1'b1;
      if (adr == DEPTH - 1) ref_fin = 1'b1;
    end
    #1;
    chk("fin", {31'd0, bus.fin}, {31'd0, ref_fin});
    if (ref_dk) chk("dat_o", {24'd0, bus.dat_o}, {24'd0, ref_dout});
  endtask

  // Reset asserted mid-cycle with random inputs, held across one clock edge.
  task automatic pulse_reset();
    int a;
    @(posedge clk_i);
    #2;
    a = $urandom_range(0, DEPTH - 1);
    bus.we_i  = 1'b1;
    bus.re_i  = 1'($urandom);
    bus.adr_i = a[AW-1:0];
    bus.dat_i = 8'($urandom);
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_dat_o", {24'd0, bus.dat_o}, 32'd0);
    chk("rst_fin", {31'd0, bus.fin}, 32'd0);
    @(posedge clk_i);
    #1;
    chk("rst_hold_dat_o", {24'd0, bus.dat_o}, 32'd0);
    chk("rst_hold_fin", {31'd0, bus.fin}, 32'd0);
    @(negedge clk_i);
    rst = 1'b0;
    bus.we_i = 1'b0;
    bus.re_i = 1'b0;
  endtask

  initial begin
    bit          saw_fin;
    logic [7:0]  v3;
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i]   = 8'h00;
      ref_known[i] = 1'b0;
    end
    bus.we_i  = 1'b0;
    bus.re_i  = 1'b0;
    bus.adr_i = '0;
    bus.dat_i = '0;
    model_reset();

    // Power-up reset
    #3 rst = 1'b1;
    #1;
    chk("por_dat_o", {24'd0, bus.dat_o}, 32'd0);
    chk("por_fin", {31'd0, bus.fin}, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst = 1'b0;

    // Write / readback / hold
    step(1, 0, 0, 8'hA5);
    step(1, 0, 10, 8'h3C);
    step(0, 1, 0, 8'h00);
    chk("rd_addr0", {24'd0, bus.dat_o}, 32'hA5);
    step(0, 1, 10, 8'h00);
    chk("rd_addr10", {24'd0, bus.dat_o}, 32'h3C);
    step(0, 0, 0, 8'h00);
    chk("rd_hold", {24'd0, bus.dat_o}, 32'h3C);

    // Read-during-write is read-first
    step(1, 0, 5, 8'h11);
    step(1, 1, 5, 8'h22);
    chk("rdw_old", {24'd0, bus.dat_o}, 32'h11);
    step(0, 1, 5, 8'h00);
    chk("rdw_new", {24'd0, bus.dat_o}, 32'h22);

    // Out of range write/read
    step(1, 0, DEPTH, 8'h77);
    step(0, 1, DEPTH, 8'h00);
    chk("oor_rd", {24'd0, bus.dat_o}, 32'h00);
    for (int i = 0; i < DEPTH; i++) if (ref_known[i]) step(0, 1, i, 8'h00);

    // Fill every location; fin only after the last one
    saw_fin = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.fin) saw_fin = 1'b1;
      step(1, 0, i, 8'(i * 7 + 8'h31));
    end
    chk("fin_late", {31'd0, saw_fin}, 32'd0);
    chk("fin_set", {31'd0, bus.fin}, 32'd1);
    v3 = ref_mem[3];
    step(1, 0, 3, 8'hFF);
    step(0, 1, 3, 8'h00);
    chk("frozen_addr3", {24'd0, bus.dat_o}, {24'd0, v3});
    chk("fin_sticky", {31'd0, bus.fin}, 32'd1);
    for (int i = 0; i < DEPTH; i++) step(0, 1, i, 8'h00);

    // Reset after full: writes reopen, old data kept
    pulse_reset();
    step(1, 0, 4, 8'h99);
    step(0, 1, 4, 8'h00);
    chk("post_rst_wr", {24'd0, bus.dat_o}, 32'h99);
    step(0, 1, 7, 8'h00);
    chk("post_rst_keep", {24'd0, bus.dat_o}, {24'd0, 8'(7 * 7 + 8'h31)});

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) pulse_reset();
      else step(1'($urandom), 1'($urandom), $urandom_range(0, DEPTH + 3), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
